// File: rtl/div_result_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : div_result_bcd
//  Description : Sequential binary-to-BCD converter placed after the 8-bit
//                restoring divider. On start (sampled in IDLE) it latches the
//                quotient and remainder, converts each one serially with
//                shift-and-add-3 (double dabble, 8 shifts per value) and
//                presents 3-digit packed BCD results with a one-cycle done.
//  Ports       : clk      - rising-edge clock
//                rst      - synchronous active-high reset
//                start    - conversion request, ignored unless idle
//                quot     - 8-bit binary quotient
//                rem      - 8-bit binary remainder
//                busy     - high whenever not idle
//                done     - one-cycle pulse, results valid
//                quot_bcd - {hundreds, tens, units} of quotient
//                rem_bcd  - {hundreds, tens, units} of remainder
//  Config      : DIV_RESULT_BCD_REM_EN - when defined the remainder is also
//                converted (latency 17); otherwise rem is ignored, rem_bcd
//                is tied to zero and the latency is 9.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_result_bcd (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  quot,
    input  logic [7:0]  rem,
    output logic        busy,
    output logic        done,
    output logic [11:0] quot_bcd,
    output logic [11:0] rem_bcd
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONV_Q = 2'd1;
`ifdef DIV_RESULT_BCD_REM_EN
    localparam logic [1:0] S_CONV_R = 2'd2;
`endif
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [7:0]  op_q, op_d;        // operand being shifted out, MSB first
    logic [11:0] acc_q, acc_d;      // BCD digit accumulator
    logic [2:0]  cnt_q, cnt_d;      // shifts done for the current value
    logic [11:0] qres_q, qres_d;    // finished quotient digits
    logic [11:0] quot_bcd_q, quot_bcd_d;
    // done_q also splits DONE into two cycles: the first loads the outputs,
    // the second (done high) returns to IDLE.
    logic        done_q, done_d;
`ifdef DIV_RESULT_BCD_REM_EN
    logic [7:0]  rem_lat_q, rem_lat_d;
    logic [11:0] rres_q, rres_d;
    logic [11:0] rem_bcd_q, rem_bcd_d;
`endif

    logic [11:0] w_adj;
    logic [11:0] w_shift;
    logic        w_last;
    logic        w_unused_bits;

    // Add 3 to every digit >= 5 before the shift so that it carries
    // correctly into the next digit after doubling.
    assign w_adj[3:0]   = (acc_q[3:0]   >= 4'd5) ? acc_q[3:0]   + 4'd3 : acc_q[3:0];
    assign w_adj[7:4]   = (acc_q[7:4]   >= 4'd5) ? acc_q[7:4]   + 4'd3 : acc_q[7:4];
    assign w_adj[11:8]  = (acc_q[11:8]  >= 4'd5) ? acc_q[11:8]  + 4'd3 : acc_q[11:8];
    assign w_shift      = {w_adj[10:0], op_q[7]};
    assign w_last       = (cnt_q == 3'd7);

    // Hundreds digit never exceeds 2, so its top bit is never shifted out.
`ifdef DIV_RESULT_BCD_REM_EN
    assign w_unused_bits = w_adj[11];
`else
    assign w_unused_bits = ^{w_adj[11], rem};
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_CONV_Q;
`ifdef DIV_RESULT_BCD_REM_EN
            S_CONV_Q: if (w_last) state_d = S_CONV_R;
            S_CONV_R: if (w_last) state_d = S_DONE;
`else
            S_CONV_Q: if (w_last) state_d = S_DONE;
`endif
            S_DONE:   if (done_q) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = done_q;
        quot_bcd = quot_bcd_q;
`ifdef DIV_RESULT_BCD_REM_EN
        rem_bcd  = rem_bcd_q;
`else
        rem_bcd  = 12'h000;
`endif
    end

    // ---------------- Datapath next values ----------------
    always_comb begin
        op_d       = op_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        qres_d     = qres_q;
        quot_bcd_d = quot_bcd_q;
        done_d     = 1'b0;
`ifdef DIV_RESULT_BCD_REM_EN
        rem_lat_d  = rem_lat_q;
        rres_d     = rres_q;
        rem_bcd_d  = rem_bcd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d      = quot;
`ifdef DIV_RESULT_BCD_REM_EN
                    rem_lat_d = rem;
`endif
                    acc_d     = 12'h000;
                    cnt_d     = 3'd0;
                end
            end
            S_CONV_Q: begin
                op_d  = {op_q[6:0], 1'b0};
                acc_d = w_shift;
                cnt_d = cnt_q + 3'd1;
                if (w_last) begin
                    qres_d = w_shift;
                    acc_d  = 12'h000;
                    cnt_d  = 3'd0;
`ifdef DIV_RESULT_BCD_REM_EN
                    op_d   = rem_lat_q;
`endif
                end
            end
`ifdef DIV_RESULT_BCD_REM_EN
            S_CONV_R: begin
                op_d  = {op_q[6:0], 1'b0};
                acc_d = w_shift;
                cnt_d = cnt_q + 3'd1;
                if (w_last) begin
                    rres_d = w_shift;
                    acc_d  = 12'h000;
                    cnt_d  = 3'd0;
                end
            end
`endif
            S_DONE: begin
                if (!done_q) begin
                    quot_bcd_d = qres_q;
`ifdef DIV_RESULT_BCD_REM_EN
                    rem_bcd_d  = rres_q;
`endif
                    done_d     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= 8'h00;
            acc_q      <= 12'h000;
            cnt_q      <= 3'd0;
            qres_q     <= 12'h000;
            quot_bcd_q <= 12'h000;
            done_q     <= 1'b0;
`ifdef DIV_RESULT_BCD_REM_EN
            rem_lat_q  <= 8'h00;
            rres_q     <= 12'h000;
            rem_bcd_q  <= 12'h000;
`endif
        end else begin
            op_q       <= op_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            qres_q     <= qres_d;
            quot_bcd_q <= quot_bcd_d;
            done_q     <= done_d;
`ifdef DIV_RESULT_BCD_REM_EN
            rem_lat_q  <= rem_lat_d;
            rres_q     <= rres_d;
            rem_bcd_q  <= rem_bcd_d;
`endif
        end
    end

endmodule
`default_nettype wire
